// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch-path definitions: opcode constants, widths and fetch FSM states.
package legv8_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 11;

   localparam logic [OPCODE_W-1:0] OP_LDUR = 11'h7C2;
   localparam logic [OPCODE_W-1:0] OP_STUR = 11'h7C0;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 11'h458;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 11'h658;
   localparam logic [OPCODE_W-1:0] OP_AND  = 11'h450;
   localparam logic [OPCODE_W-1:0] OP_ORR  = 11'h550;

   // CBZ fixes only the upper 8 opcode bits (10110100xxx); low 3 bits belong to the offset.
   localparam logic [OPCODE_W-1:0] OP_CBZ      = 11'b10110100000;
   localparam logic [OPCODE_W-1:0] OP_CBZ_MASK = 11'b11111111000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } fetch_state_t;

   function automatic logic is_cbz(input logic [OPCODE_W-1:0] op);
      return (op & OP_CBZ_MASK) == OP_CBZ;
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg: program counter with async active-low reset, redirect/advance next-PC mux.
module pc_reg
   import legv8_pkg::*;
#(
   parameter int unsigned   N        = 64,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         redirect_i,
   input  logic [N-1:0] target_i,
   input  logic         advance_i,
   output logic [N-1:0] pc_o
);

   localparam logic [N-1:0] WORD_MASK = {{(N-2){1'b1}}, 2'b00};
   localparam logic [N-1:0] WORD_STEP = {{(N-3){1'b0}}, 3'd4};

   logic [N-1:0] pc_q;
   logic [N-1:0] pc_d;

   // Next PC: redirect wins over sequential advance; addition wraps modulo 2^N.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = target_i & WORD_MASK;
      end else if (advance_i) begin
         pc_d = pc_q + WORD_STEP;
      end
   end

   // PC register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC & WORD_MASK;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches words over req/gnt/rvalid and hands them to decode
// through a single-entry valid/ready output register. Accepts branch redirects.
module instr_fetch
   import legv8_pkg::*;
#(
   parameter int unsigned   N        = 64,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [N-1:0]        imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic [N-1:0]        instr_pc,
   input  logic                br_taken,
   input  logic [N-1:0]        br_target
);

   fetch_state_t       state_q;
   logic               drop_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [N-1:0]       ipc_q;
   logic [N-1:0]       pc;

   logic handshake;
   logic word_in;
   logic accept;

   assign handshake = valid_q & instr_ready;
   assign word_in   = (state_q == WAIT) & imem_rvalid;
   // A word is kept only if it is neither stale (drop) nor overtaken by a redirect this cycle.
   assign accept    = word_in & ~drop_q & ~br_taken;

   pc_reg #(
      .N        (N),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i      (clk),
      .rst_ni     (reset),
      .redirect_i (br_taken),
      .target_i   (br_target),
      .advance_i  (accept),
      .pc_o       (pc)
   );

   // Fetch FSM, stale-response tracking and the decode-facing output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         if (br_taken) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            ipc_q   <= pc;
         end else if (handshake) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!valid_q || instr_ready || br_taken) begin
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (imem_gnt) begin
                  state_q <= WAIT;
                  drop_q  <= br_taken;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  drop_q  <= 1'b0;
                  state_q <= (drop_q || br_taken) ? REQ : IDLE;
               end else if (br_taken) begin
                  drop_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];
   assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scripted memory responder, transaction-level expected-PC model
// checked every cycle, plus directed literal expectations.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] instr_pc;
   logic        br_taken;
   logic [63:0] br_target;

   int total = 0;
   int bad   = 0;

   instr_fetch #(
      .N        (64),
      .RESET_PC (64'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .opcode      (opcode),
      .instr_pc    (instr_pc),
      .br_taken    (br_taken),
      .br_target   (br_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Instruction memory contents seen by the responder and the model.
   function automatic logic [31:0] word_at(input logic [63:0] a);
      case (a)
         64'h0:   return 32'hF840_0000;   // LDUR
         64'h4:   return 32'h8B02_0020;   // ADD
         64'h8:   return 32'h8A00_0000;   // AND
         64'hC:   return 32'hAA00_0000;   // ORR
         64'h10:  return 32'hCB00_0000;   // SUB
         default: return {8'hB4, a[23:0]}; // CBZ family
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (instr_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check(name, 64'(instr_valid), 64'd1);
   endtask

   // Memory responder: gnt after gnt_lat REQ cycles, rvalid rv_lat cycles after gnt.
   int          gnt_lat = 0;
   int          rv_lat  = 1;
   int          req_age = 0;
   int          pend_wait = 0;
   logic        pend = 1'b0;
   logic [63:0] pend_addr = '0;
   logic        inj = 1'b0;

   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(posedge clk);
         #2;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         if (!reset) begin
            pend    = 1'b0;
            req_age = 0;
         end else begin
            if (inj) begin
               imem_rvalid = 1'b1;
               imem_rdata  = 32'hDEAD_BEEF;
            end else if (pend) begin
               if (pend_wait <= 1) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = word_at(pend_addr);
                  pend        = 1'b0;
               end else begin
                  pend_wait--;
               end
            end
            if (imem_req && !pend) begin
               if (req_age >= gnt_lat) begin
                  imem_gnt  = 1'b1;
                  pend      = 1'b1;
                  pend_addr = imem_addr;
                  pend_wait = rv_lat;
                  req_age   = 0;
               end else begin
                  req_age++;
               end
            end else if (!imem_req) begin
               req_age = 0;
            end
         end
      end
   end

   // Model: model_pc is the address of the next instruction decode must see.
   logic [63:0] model_pc;
   int          hs_count;

   initial begin
      logic [31:0] w;
      model_pc = 64'h0;
      hs_count = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            model_pc = 64'h0;
            continue;
         end
         w = word_at(model_pc);
         if (imem_req) begin
            check("model_req_addr", imem_addr, model_pc);
         end
         if (instr_valid) begin
            check("model_instr_pc", instr_pc, model_pc);
            check("model_instr", 64'(instr), 64'(w));
            check("model_opcode", 64'(opcode), 64'(w[31:21]));
            if (instr_ready) begin
               model_pc = model_pc + 64'd4;
               hs_count++;
            end
         end
         if (br_taken) begin
            model_pc = br_target & ~64'h3;
         end
      end
   end

   int hs_before;

   initial begin
      reset       = 1'b0;
      instr_ready = 1'b0;
      br_taken    = 1'b0;
      br_target   = '0;

      // Reset state
      step();
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(instr_valid), 64'd0);
      step();
      check("rst_req2", 64'(imem_req), 64'd0);
      check("rst_pc", instr_pc, 64'd0);
      check("rst_opcode", 64'(opcode), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      reset       = 1'b1;
      instr_ready = 1'b1;

      // First fetch latency and sequential stream
      step();
      check("lat_req", 64'(imem_req), 64'd1);
      check("lat_addr", imem_addr, 64'd0);
      check("lat_valid1", 64'(instr_valid), 64'd0);
      step();
      check("lat_valid2", 64'(instr_valid), 64'd0);
      step();
      check("lat_valid3", 64'(instr_valid), 64'd1);
      check("ldur_opcode", 64'(opcode), 64'h7C2);
      check("ldur_pc", instr_pc, 64'h0);
      step();
      check("addr4_req", 64'(imem_req), 64'd1);
      check("addr4", imem_addr, 64'h4);
      step();
      step();
      check("add_valid", 64'(instr_valid), 64'd1);
      check("add_opcode", 64'(opcode), 64'h458);
      check("add_pc", instr_pc, 64'h4);
      step();
      check("addr8", imem_addr, 64'h8);
      instr_ready = 1'b0;

      // Back-pressure hold
      step();
      step();
      check("and_valid", 64'(instr_valid), 64'd1);
      check("and_opcode", 64'(opcode), 64'h450);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_valid", 64'(instr_valid), 64'd1);
         check("hold_pc", instr_pc, 64'h8);
         check("hold_instr", 64'(instr), 64'h8A00_0000);
         check("hold_req", 64'(imem_req), 64'd0);
      end
      instr_ready = 1'b1;
      step();
      check("drain_valid", 64'(instr_valid), 64'd0);
      check("drain_req", 64'(imem_req), 64'd1);
      check("drain_addr", imem_addr, 64'hC);
      rv_lat = 2;

      // Redirect during WAIT: returned word dropped
      step();
      br_taken  = 1'b1;
      br_target = 64'h43;
      step();
      br_taken = 1'b0;
      rv_lat   = 1;
      check("drop_valid", 64'(instr_valid), 64'd0);
      step();
      check("drop_valid2", 64'(instr_valid), 64'd0);
      check("redir_req", 64'(imem_req), 64'd1);
      check("redir_addr", imem_addr, 64'h40);
      step();
      step();
      check("cbz_valid", 64'(instr_valid), 64'd1);
      check("cbz_pc", instr_pc, 64'h40);
      check("cbz_opcode", 64'(opcode), 64'h5A0);
      br_taken  = 1'b1;
      br_target = 64'h80;
      hs_before = hs_count;
      step();
      br_taken = 1'b0;
      check("redir_hs_valid", 64'(instr_valid), 64'd0);
      check("redir_hs_addr", imem_addr, 64'h80);
      check("redir_hs_count", 64'(hs_count), 64'(hs_before + 1));
      hs_before = hs_count;
      step();
      step();
      check("post_redir_pc", instr_pc, 64'h80);
      check("post_redir_hs", 64'(hs_count), 64'(hs_before));

      // Redirect in REQ with gnt the same cycle
      step();
      check("reqgnt_addr", imem_addr, 64'h84);
      br_taken  = 1'b1;
      br_target = 64'h100;
      step();
      br_taken = 1'b0;
      check("reqgnt_req", 64'(imem_req), 64'd0);
      check("reqgnt_valid", 64'(instr_valid), 64'd0);
      step();
      check("reqgnt_req2", 64'(imem_req), 64'd1);
      check("reqgnt_addr2", imem_addr, 64'h100);

      // Redirect coinciding with rvalid: discard, no lingering drop
      step();
      br_taken  = 1'b1;
      br_target = 64'h200;
      step();
      br_taken = 1'b0;
      check("coinc_valid", 64'(instr_valid), 64'd0);
      check("coinc_addr", imem_addr, 64'h200);
      step();
      step();
      check("coinc_valid2", 64'(instr_valid), 64'd1);
      check("coinc_pc", instr_pc, 64'h200);
      gnt_lat = 2;

      // Redirect in REQ without gnt, to the top word, then wrap
      step();
      check("nogrant_addr", imem_addr, 64'h204);
      br_taken  = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      br_taken = 1'b0;
      check("nogrant_req", 64'(imem_req), 64'd1);
      check("nogrant_addr2", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_valid("top_valid");
      check("top_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("top_opcode", 64'(opcode), 64'h5A7);
      step();
      check("wrap_req", 64'(imem_req), 64'd1);
      check("wrap_addr", imem_addr, 64'h0);
      gnt_lat = 0;
      rv_lat  = 3;

      // Reset in WAIT with a pending drop; late rvalid after release ignored
      step();
      br_taken  = 1'b1;
      br_target = 64'h300;
      step();
      br_taken = 1'b0;
      reset    = 1'b0;
      #1;
      check("mid_rst_req", 64'(imem_req), 64'd0);
      check("mid_rst_valid", 64'(instr_valid), 64'd0);
      check("mid_rst_addr", imem_addr, 64'h0);
      step();
      step();
      reset   = 1'b1;
      gnt_lat = 2;
      rv_lat  = 1;
      inj     = 1'b1;
      step();
      step();
      inj = 1'b0;
      check("late_rv_valid", 64'(instr_valid), 64'd0);
      check("late_rv_req", 64'(imem_req), 64'd1);
      check("late_rv_addr", imem_addr, 64'h0);
      step();
      step();
      step();
      check("restart_valid", 64'(instr_valid), 64'd1);
      check("restart_pc", instr_pc, 64'h0);
      check("restart_opcode", 64'(opcode), 64'h7C2);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
